// File: rtl/button_pkg.sv
// Shared types, board timing defaults and a counter-width helper for the
// push-button / switch input conditioner.
// Latency: n/a (package). Backpressure: n/a (package).
// Contents: edge_mode_t, rep_state_t, DEF_* timing constants, cnt_width().
package button_pkg;

  // Which debounced transitions produce an event pulse.
  typedef enum logic [1:0] {
    EDGE_RISE,
    EDGE_FALL,
    EDGE_BOTH
  } edge_mode_t;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  // Timing defaults for the 50 MHz board clock.
  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50_000;      // 1 ms
  localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms

  // Bits needed to hold 0..max_val; never less than one bit so that a
  // counter whose terminal value is 0 still has a legal declaration.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One input channel: synchroniser, debouncer, edge detector and optional
// hold-to-auto-repeat. level_o moves SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after
// the sampling edge (counting that edge), pulse_o is registered alongside it.
// Backpressure: none; every accepted event is a single-cycle pulse.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   in_i           raw asynchronous input, active high
//   level_o        debounced level
//   pulse_o        one-cycle event pulse (edge or auto-repeat)
//   repeat_flag_o  high with pulse_o when the pulse is an auto-repeat
module button_channel
  import button_pkg::*;
#(
  parameter int         SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter edge_mode_t EDGE_MODE       = EDGE_RISE,
  parameter int         REPEAT_EN       = 0,
  parameter int         REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int         REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic level_o,
  output logic pulse_o,
  output logic repeat_flag_o
);

  // ---------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_channel: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_channel: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_EN != 0 && REPEAT_EN != 1) begin : g_bad_repeat_en
    $error("button_channel: REPEAT_EN must be 0 or 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("button_channel: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("button_channel: REPEAT_PERIOD must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Counter sizing. Both counters clear on their terminal value, so they
  // only ever need to reach (limit - 1).
  // ---------------------------------------------------------------------
  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int RP_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int RC_W   = cnt_width(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DLY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PER_LAST = RC_W'(REPEAT_PERIOD - 1);

  localparam bit RISE_EN = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);
  localparam bit FALL_EN = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  rep_state_t             state_q, state_d;
  logic [RC_W-1:0]        rcnt_q, rcnt_d;

  logic sync_s;     // synchronised input
  logic flip;       // debounced level changes on this edge
  logic rise;
  logic fall;
  logic rep_fire;   // auto-repeat pulse on this edge

  // ---------------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------------
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], in_i};
    sync_s   = sync_q[SYNC_STAGES-1];
    level_d  = level_q;
    db_cnt_d = '0;
    flip     = 1'b0;

    // Any cycle where the synchronised value agrees with the accepted level
    // restarts the count, so only an unbroken run of disagreement flips it.
    if (sync_s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        flip    = 1'b1;
        level_d = sync_s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    rise = flip & sync_s;
    fall = flip & ~sync_s;
  end

  // ---------------------------------------------------------------------
  // Auto-repeat FSM (next state)
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rep_fire = 1'b0;

    if (REPEAT_EN != 0) begin
      case (state_q)
        IDLE: begin
          // Only a debounced press arms the timer; level=1 straight out of
          // reset is not a press.
          if (rise) begin
            state_d = DELAY;
            rcnt_d  = '0;
          end
        end
        DELAY: begin
          // A release wins over a coincident terminal count.
          if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == DLY_LAST) begin
            rep_fire = 1'b1;
            state_d  = REPEAT;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RC_W'(1);
          end
        end
        REPEAT: begin
          if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == PER_LAST) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RC_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output pulse. A repeat can never coincide with a rise (repeats only fire
  // while the level is already high), so the flag marks repeats exactly.
  // ---------------------------------------------------------------------
  always_comb begin
    pulse_d = (rise & RISE_EN) | (fall & FALL_EN) | rep_fire;
    flag_d  = rep_fire;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '1;
      level_q  <= 1'b1;
      db_cnt_q <= '0;
      pulse_q  <= 1'b0;
      flag_q   <= 1'b0;
      state_q  <= IDLE;
      rcnt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      pulse_q  <= pulse_d;
      flag_q   <= flag_d;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign level_o       = level_q;
  assign pulse_o       = pulse_q;
  assign repeat_flag_o = flag_q;

endmodule

// File: rtl/button_conditioner.sv
// N independent push-button / switch conditioners (sync, debounce, edge
// detect, optional auto-repeat). Latency per channel as in button_channel.
// Backpressure: none; events are single-cycle pulses.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   in           raw asynchronous inputs, active high
//   level        debounced level per channel
//   pulse        one-cycle event pulse per channel
//   repeat_flag  high with pulse[i] when that pulse is an auto-repeat
module button_conditioner
  import button_pkg::*;
#(
  parameter int         N               = 4,
  parameter int         SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter edge_mode_t EDGE_MODE       = EDGE_RISE,
  parameter int         REPEAT_EN       = 0,
  parameter int         REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int         REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse,
  output logic [N-1:0] repeat_flag
);

  if (N < 1) begin : g_bad_n
    $error("button_conditioner: N must be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .in_i          (in[i]),
      .level_o       (level[i]),
      .pulse_o       (pulse[i]),
      .repeat_flag_o (repeat_flag[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: four instances share one input/reset stream
// (RISE, FALL, RISE+repeat, BOTH) and are compared every cycle against a
// history-based reference model, plus directed event counts per scenario.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in;

  logic [1:0] lvl_r, pul_r, flg_r;
  logic [1:0] lvl_f, pul_f, flg_f;
  logic [1:0] lvl_p, pul_p, flg_p;
  logic [1:0] lvl_b, pul_b, flg_b;

  always #5 clk = ~clk;

  button_conditioner #(.N(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_RISE),
                       .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u_rise (.clk(clk), .reset(reset), .in(in), .level(lvl_r), .pulse(pul_r), .repeat_flag(flg_r));
  button_conditioner #(.N(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_FALL),
                       .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u_fall (.clk(clk), .reset(reset), .in(in), .level(lvl_f), .pulse(pul_f), .repeat_flag(flg_f));
  button_conditioner #(.N(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_RISE),
                       .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u_rep  (.clk(clk), .reset(reset), .in(in), .level(lvl_p), .pulse(pul_p), .repeat_flag(flg_p));
  button_conditioner #(.N(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_BOTH),
                       .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u_both (.clk(clk), .reset(reset), .in(in), .level(lvl_b), .pulse(pul_b), .repeat_flag(flg_b));

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  int         k;              // edges since reset release
  logic [1:0] in_hist[$];     // in value sampled at edge 1, 2, ...
  logic [1:0] m_level;
  logic [1:0] e_rise, e_fall, e_rep;
  int         press_at[2];
  bit         armed[2];

  // Synchronised value seen by the debouncer at edge idx.
  function automatic logic s_at(input int idx, input int ch);
    if (idx >= SYNC + 1) return in_hist[idx-SYNC-1][ch];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst, input logic [1:0] vin);
    if (rst) begin
      k = 0;
      in_hist.delete();
      m_level = 2'b11;
      e_rise = '0; e_fall = '0; e_rep = '0;
      for (int ch = 0; ch < 2; ch++) begin
        armed[ch] = 0;
        press_at[ch] = 0;
      end
    end else begin
      k++;
      in_hist.push_back(vin);
      for (int ch = 0; ch < 2; ch++) begin
        bit flip;
        int d;
        // Level flips once DEB consecutive synchronised samples disagree with it.
        flip = (k >= DEB);
        for (int j = 0; j < DEB; j++)
          if (flip && s_at(k - j, ch) == m_level[ch]) flip = 0;
        e_rise[ch] = flip && !m_level[ch];
        e_fall[ch] = flip && m_level[ch];
        if (flip) m_level[ch] = ~m_level[ch];
        e_rep[ch] = 1'b0;
        if (e_fall[ch]) begin
          armed[ch] = 0;
        end else if (armed[ch]) begin
          d = k - press_at[ch];
          if (d == RD || (d > RD && (d - RD) % RP == 0)) e_rep[ch] = 1'b1;
        end
        if (e_rise[ch]) begin
          armed[ch] = 1;
          press_at[ch] = k;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, want, k);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int want);
    tests++;
    assert (obs == want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Directed-scenario event counters, read back from the DUT outputs.
  int c_rise_p[2], c_fall_p[2], c_rep_press[2], c_rep_flag[2], c_flag_low[2];
  int c_both_11, c_both_bits;

  task automatic clr();
    for (int ch = 0; ch < 2; ch++) begin
      c_rise_p[ch] = 0; c_fall_p[ch] = 0; c_rep_press[ch] = 0;
      c_rep_flag[ch] = 0; c_flag_low[ch] = 0;
    end
    c_both_11 = 0;
    c_both_bits = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(reset, in);
    #1;
    check("rise.level", lvl_r, m_level);
    check("rise.pulse", pul_r, e_rise);
    check("rise.flag",  flg_r, 2'b00);
    check("fall.level", lvl_f, m_level);
    check("fall.pulse", pul_f, e_fall);
    check("fall.flag",  flg_f, 2'b00);
    check("rep.level",  lvl_p, m_level);
    check("rep.pulse",  pul_p, e_rise | e_rep);
    check("rep.flag",   flg_p, e_rep);
    check("both.level", lvl_b, m_level);
    check("both.pulse", pul_b, e_rise | e_fall);
    check("both.flag",  flg_b, 2'b00);
    for (int ch = 0; ch < 2; ch++) begin
      c_rise_p[ch]    += int'(pul_r[ch]);
      c_fall_p[ch]    += int'(pul_f[ch]);
      c_rep_press[ch] += int'(pul_p[ch] & ~flg_p[ch]);
      c_rep_flag[ch]  += int'(flg_p[ch]);
      c_flag_low[ch]  += int'(flg_p[ch] & ~lvl_p[ch]);
      c_both_bits     += int'(pul_b[ch]);
    end
    if (pul_b == 2'b11) c_both_11++;
  endtask

  task automatic run(input logic [1:0] v, input int n);
    in = v;
    repeat (n) tick();
  endtask

  initial begin
    int at;
    reset = 1'b1;
    in = 2'b00;
    clr();

    // 1. Reset with inputs low: level 11 -> 00 at edge 6, falling pulse only.
    repeat (3) tick();
    reset = 1'b0;
    clr();
    at = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (at < 0 && lvl_r == 2'b00) at = t;
    end
    check_int("s1.level_low_edge", at, 6);
    check_int("s1.rise_pulses", c_rise_p[0] + c_rise_p[1], 0);
    check_int("s1.fall_pulses", c_fall_p[0] + c_fall_p[1], 2);

    // 2. Clean press on ch0, ch1 held low.
    clr();
    in = 2'b01;
    at = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (at < 0 && lvl_r[0]) at = t;
    end
    check_int("s2.level_rise_edge", at, 6);
    check_int("s2.press_pulses0", c_rise_p[0], 1);
    check_int("s2.press_pulses1", c_rise_p[1], 0);
    run(2'b00, 12);

    // 3. Glitch of 3 cycles is rejected; 4 cycles is accepted.
    clr();
    at = 0;
    in = 2'b01;
    repeat (3) begin tick(); at += int'(lvl_r[0]); end
    in = 2'b00;
    repeat (10) begin tick(); at += int'(lvl_r[0]); end
    check_int("s3.glitch_level", at, 0);
    check_int("s3.glitch_pulse", c_rise_p[0], 0);
    run(2'b01, 4);
    run(2'b00, 12);
    check_int("s3.min_press_pulse", c_rise_p[0], 1);

    // 4. Auto-repeat: held 40 cycles -> press + 10 repeats; the repeat that
    //    would coincide with the release edge is suppressed.
    clr();
    run(2'b01, 40);
    run(2'b00, 15);
    check_int("s4.press", c_rep_press[0], 1);
    check_int("s4.repeats", c_rep_flag[0], 10);
    check_int("s4.flag_after_release", c_flag_low[0], 0);
    check_int("s4.ch1_quiet", c_rep_press[1] + c_rep_flag[1], 0);

    // 5. Button held through a reset asserted mid-DELAY.
    run(2'b01, 10);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    clr();
    run(2'b01, 30);
    check_int("s5.no_press", c_rep_press[0], 0);
    check_int("s5.no_repeat", c_rep_flag[0], 0);
    check_int("s5.level_high", int'(lvl_p[0]), 1);
    run(2'b00, 12);
    clr();
    run(2'b01, 8);
    check_int("s5.repress", c_rep_press[0], 1);
    run(2'b00, 12);

    // 6. EDGE_BOTH, both channels toggled together.
    clr();
    run(2'b11, 10);
    run(2'b00, 10);
    check_int("s6.both_11_cycles", c_both_11, 2);
    check_int("s6.both_bits", c_both_bits, 4);

    // Randomised segments: glitches, long holds, occasional reset.
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        repeat (int'($urandom_range(1, 3))) tick();
        reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0)
        run(2'($urandom_range(0, 3)), int'($urandom_range(20, 45)));
      else
        run(2'($urandom_range(0, 3)), int'($urandom_range(1, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
